// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from the TX FIFO whenever the line is idle and
// shifts each one out as start / LSB-first data / stop with a 16x timebase.
`timescale 1ns/1ps
module uart_tx_drain #(
  parameter int DATA_SIZE  = 8,
  parameter int BAUD_DIV   = 651,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_SIZE);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_SIZE - 1);
  localparam logic [5:0]    BIT_LAST  = 6'd15;
  localparam logic [5:0]    STOP_LAST = 6'(STOP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [BW-1:0]        r_baud;
  logic [5:0]           r_tick;
  logic [IW-1:0]        r_idx;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_tx;

  logic w_tick;
  logic w_bit_end;
  logic w_stop_end;

  assign w_tick     = (r_baud == BAUD_LAST);
  assign w_bit_end  = w_tick && (r_tick == BIT_LAST);
  assign w_stop_end = w_tick && (r_tick == STOP_LAST);

  // Pop is combinational so the FIFO advances on the same edge we load.
  assign fifo_read    = (r_state == S_IDLE) && !fifo_empty && !reset;
  assign tx           = r_tx;
  assign tx_busy      = (r_state != S_IDLE);
  assign tx_done_tick = (r_state == S_STOP) && w_stop_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud <= '0;
    end else if (r_state == S_IDLE) begin
      r_baud <= '0;
    end else if (w_tick) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (fifo_read) begin
            r_shift <= fifo_data;
            r_tick  <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else if (w_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_shift <= r_shift >> 1;
            if (r_idx == IDX_LAST) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_tx  <= r_shift[1];
            end
          end else if (w_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end
        S_STOP: begin
          if (w_stop_end) begin
            r_tick  <= '0;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_tick <= r_tick + 6'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: two instances (1 and 2 stop bits),
// expected frames queued at issue and checked by per-channel line monitors.
`timescale 1ns/1ps
module tb_uart_tx_drain;

  localparam int BDIV = 4;
  localparam int BITC = 16 * BDIV;
  localparam int LIM  = 3000;

  typedef struct {
    logic [7:0] data;
    bit         abort;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] fempty;
  logic [7:0] fdata [2];
  wire  [1:0] fread;
  wire  [1:0] tx;
  wire  [1:0] busy;
  wire  [1:0] done;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pops [2] = '{0, 0};
  int   dns  [2] = '{0, 0};
  int   ovl      = 0;
  bit   mact [2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  uart_tx_drain #(.DATA_SIZE(8), .BAUD_DIV(BDIV), .STOP_TICKS(16)) u_dut0 (
    .clk(clk), .reset(rst[0]), .fifo_empty(fempty[0]),
    .fifo_data(fdata[0]), .fifo_read(fread[0]), .tx(tx[0]),
    .tx_busy(busy[0]), .tx_done_tick(done[0])
  );

  uart_tx_drain #(.DATA_SIZE(8), .BAUD_DIV(BDIV), .STOP_TICKS(32)) u_dut1 (
    .clk(clk), .reset(rst[1]), .fifo_empty(fempty[1]),
    .fifo_data(fdata[1]), .fifo_read(fread[1]), .tx(tx[1]),
    .tx_busy(busy[1]), .tx_done_tick(done[1])
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (fread[g] === 1'b1) pops[g]++;
      if (done[g] === 1'b1) dns[g]++;
      if (done[g] === 1'b1 && fread[g] === 1'b1) ovl++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic monitor(input int g);
    int         st, fl, k, bt, bd, bb, last_done;
    logic [7:0] got;
    logic       prev, expv;
    bit         ab;
    exp_t       e;
    st = (g == 0) ? 16 : 32;
    fl = (16 * 9 + st) * BDIV;
    prev = 1'b1;
    last_done = -100;
    forever begin
      @(negedge clk);
      if (!rst[g] && prev && tx[g] === 1'b0) begin
        mact[g] = 1'b1;
        e = '{data: 8'h00, abort: 1'b0, b2b: 1'b0};
        if ((g == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame ch=%0d got=frame exp=none", g);
        end else if (g == 0) begin
          e = q0.pop_front();
        end else begin
          e = q1.pop_front();
        end
        if (e.b2b) chk($sformatf("b2b_gap%0d", g), cyc - last_done, 2);
        bt = 0; bd = 0; bb = 0; ab = 1'b0; got = 8'h00;
        for (int c = 1; c <= fl; c++) begin
          if (c > 1) @(negedge clk);
          if (rst[g]) begin
            ab = 1'b1;
            break;
          end
          k = (c - 1) / BITC;
          if (k == 0) expv = 1'b0;
          else if (k <= 8) expv = e.data[k-1];
          else expv = 1'b1;
          if (tx[g] !== expv) bt++;
          if ((c - 1) % BITC == BITC / 2 && k >= 1 && k <= 8)
            got[k-1] = tx[g];
          if (done[g] !== (c == fl)) bd++;
          if (busy[g] !== 1'b1) bb++;
        end
        chk($sformatf("frame_abort%0d", g), 32'(ab), 32'(e.abort));
        if (ab) begin
          chk($sformatf("rst_outs%0d", g),
              {29'd0, tx[g], busy[g], done[g]}, 32'b100);
          while (rst[g]) @(negedge clk);
        end else begin
          chk($sformatf("data%0d", g), {24'd0, got}, {24'd0, e.data});
          chk($sformatf("tx_profile%0d", g), bt, 0);
          chk($sformatf("done_timing%0d", g), bd, 0);
          chk($sformatf("busy_frame%0d", g), bb, 0);
          last_done = cyc;
          @(negedge clk);
          chk($sformatf("post_idle%0d", g),
              {29'd0, tx[g], busy[g], done[g]}, 32'b100);
        end
        prev = tx[g];
        mact[g] = 1'b0;
      end else begin
        prev = tx[g];
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int g, input logic [7:0] b,
                      input bit ab, input bit b2b);
    int n;
    fdata[g]  = b;
    fempty[g] = 1'b0;
    if (g == 0) q0.push_back('{data: b, abort: ab, b2b: b2b});
    else q1.push_back('{data: b, abort: ab, b2b: b2b});
    #1;
    n = 0;
    while (fread[g] !== 1'b1 && n < LIM) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= LIM) begin
      checks++;
      failures++;
      $display("FAIL pop_timeout ch=%0d got=no_pop exp=pop", g);
    end
    @(posedge clk);
    #1;
    fempty[g] = 1'b1;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[g] !== 1'b0 || mact[g]) && n < LIM);
    if (n >= LIM) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout ch=%0d got=busy exp=idle", g);
    end
  endtask

  initial begin
    int bad;
    rst      = 2'b11;
    fempty   = 2'b00;
    fdata[0] = 8'h99;
    fdata[1] = 8'h99;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (fread !== 2'b00 || tx !== 2'b11 || busy !== 2'b00 || done !== 2'b00)
        bad++;
    end
    chk("reset_state", bad, 0);
    chk("reset_tx", {30'd0, tx}, 32'b11);
    fempty = 2'b11;
    #2;
    rst = 2'b00;

    repeat (3) @(negedge clk);
    send(0, 8'hA5, 1'b0, 1'b0);
    wait_idle(0);

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fread[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    chk("empty_idle", bad, 0);

    send(0, 8'h00, 1'b0, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b1);
    wait_idle(0);

    repeat (4) @(negedge clk);
    send(0, 8'h3C, 1'b1, 1'b0);
    repeat (276) @(negedge clk);
    #2;
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b0);
    wait_idle(0);

    send(1, 8'h55, 1'b0, 1'b0);
    wait_idle(1);
    repeat (5) @(negedge clk);

    chk("pops0", pops[0], 5);
    chk("pops1", pops[1], 1);
    chk("dones0", dns[0], 4);
    chk("dones1", dns[1], 1);
    chk("done_read_overlap", ovl, 0);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmit stage that sits directly downstream of the UART transmit FIFO. It pops one byte at a time from the FIFO whenever the FIFO is non-empty and the line is idle. Each byte is shifted out as a standard asynchronous frame: start bit, DATA_SIZE data bits LSB first, stop period, no parity. A divisor-based baud timebase is built in and generates 16 ticks per bit.

## Interface
- DATA_SIZE, 8: bits per data word; matches FIFO word width.
- BAUD_DIV, 651: clk cycles per oversample tick (100 MHz / (16 × 9600)); legal range ≥ 2.
- STOP_TICKS, 16: oversample ticks in the stop period; legal values 16, 24, 32 (1, 1.5, 2 stop bits).
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_SIZE  FIFO read data; valid whenever fifo_empty = 0.
- fifo_read  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done_tick  output  1  one-cycle pulse on the last cycle of the stop period.

## Operation
- FSM states and their tx level:
  - IDLE: tx = 1.
  - START: tx = 0.
  - DATA: tx = shift[0].
  - STOP: tx = 1.
- Internal counters:
  - baud counter: width $clog2(BAUD_DIV); wraps at BAUD_DIV-1.
  - tick counter: 6 bits.
  - bit index: $clog2(DATA_SIZE) bits.
  - shift register: DATA_SIZE bits.
- Baud counter behaviour:
  - Cleared in IDLE.
  - In other states, counts 0..BAUD_DIV-1 and wraps.
  - tick = (baud counter == BAUD_DIV-1).
- IDLE:
  - fifo_read = (state == IDLE) & ~fifo_empty & ~reset; this is combinational, so the pop lands in the same cycle.
  - On that edge: shift ← fifo_data, tick counter ← 0, baud counter ← 0, state → START.
- START:
  - On each tick, tick counter increments.
  - At tick with tick counter == 15: tick counter ← 0, bit index ← 0, state → DATA.
- DATA:
  - At tick with tick counter == 15: shift ← shift >> 1 and tick counter ← 0.
  - If bit index == DATA_SIZE-1, state → STOP; else bit index increments.
- STOP:
  - At tick with tick counter == STOP_TICKS-1: tx_done_tick = 1 for that cycle, and state → IDLE.
- tx_busy = (state != IDLE).
- No FIFO interaction outside IDLE. fifo_empty changes mid-frame are ignored.
- Never pops when fifo_empty = 1, so there is no underflow path.

## Timing
- Reset values (async; held while reset = 1):
  - tx = 1, tx_busy = 0, fifo_read = 0, tx_done_tick = 0.
  - State IDLE; all counters and shift register 0.
- Pop latency: fifo_read is high in the cycle fifo_empty is first seen low in IDLE (cycle T0).
- tx falls on the T0 edge: tx = 0 from cycle T0+1.
- Bit period: 16·BAUD_DIV cycles.
- Total frame: (16·(1+DATA_SIZE)+STOP_TICKS)·BAUD_DIV cycles, from tx falling to the end of the stop period.
- Back-to-back frames: after tx_done_tick, exactly one IDLE cycle, in which fifo_read may assert. The next start bit begins one cycle later. Minimum inter-frame gap: 1 clk of extra high level.
- tx_done_tick and fifo_read never assert in the same cycle.
- Reset mid-frame:
  - tx returns to 1 immediately.
  - The in-flight byte is dropped and not re-popped.
  - No tx_done_tick is generated.
- tx is glitch-free: it is driven only from the registered state and shift register.

## Test plan
- Reset: assert reset with fifo_empty = 0 → fifo_read = 0, tx = 1, tx_busy = 0 throughout reset.
- Single byte:
  - Setup: BAUD_DIV = 4, STOP_TICKS = 16; present 0xA5 with fifo_empty = 0.
  - Pop: fifo_read exactly 1 cycle.
  - tx sequence: 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. Each level lasts 64 cycles.
  - Completion: tx_done_tick at cycle 640 after tx falls; tx_busy drops the next cycle.
- Back-to-back:
  - Setup: FIFO holds 0x00, 0xFF.
  - Pops: exactly 2 pops.
  - Timing: second start bit begins 2 cycles after the first tx_done_tick cycle.
  - Frames: the 0x00 frame shows 9×64 cycles low; the 0xFF frame shows 64 low, then high.
- Empty FIFO: fifo_empty = 1 for 1000 cycles → no fifo_read, tx = 1, tx_busy = 0.
- Mid-frame reset:
  - Stimulus: reset pulse during data bit 3 of 0x3C.
  - Response: tx = 1 within the reset cycle; no tx_done_tick; the next byte starts a clean frame.
- Two stop bits: STOP_TICKS = 32, byte 0x55 → stop high for 128 cycles (BAUD_DIV = 4) before tx_done_tick.
